// File: rtl/dis_pal_encode.sv
// rtl/dis_pal_encode.sv - Avalon-ST video packetiser: control packet + video data packet per frame
//
// Purpose:
//   Wraps each incoming raw pixel frame into Avalon-ST video packets. An
//   optional control packet (type 0xF) carries the width, height and interlace
//   nibbles. It is followed by a video data packet (type 0x0) that carries the
//   pixels, which are passed through combinationally.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   din_*                 raw pixel stream in (data/valid/sop/eop, ready out)
//   dout_*                Avalon-ST video stream out (data/valid/sop/eop, ready in)
//   im_width/height       frame geometry, sampled at frame start
//   im_interlaced         interlace nibble, sampled at frame start
//   ctrl_en               emit control packet for this frame, sampled at frame start

module dis_pal_encode #(
  parameter int DATA_WIDTH   = 14,
  parameter int COLOR_BITS   = 14,
  parameter int COLOR_PLANES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready,
  input  logic [15:0]           im_width,
  input  logic [15:0]           im_height,
  input  logic [3:0]            im_interlaced,
  input  logic                  ctrl_en
);

  // Nine nibbles (w:4, h:4, i:1) spread over COLOR_PLANES nibbles per beat.
  localparam int         N_BODY    = (9 + COLOR_PLANES - 1) / COLOR_PLANES;
  localparam logic [3:0] LAST_BEAT = 4'(N_BODY - 1);

  typedef enum logic [2:0] {
    IDLE,
    CTRL_TYPE,
    CTRL_BODY,
    DATA_TYPE,
    DATA
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_beat_cnt;
  logic [15:0]           r_w;
  logic [15:0]           r_h;
  logic [3:0]            r_i;
  logic                  r_ctrl;
  logic [3:0]            w_nib [9];
  logic [DATA_WIDTH-1:0] w_body;
  logic                  w_sof;

  assign w_sof = din_valid & din_startofpacket;

  // Control body nibbles in transmit order, most significant first.
  always_comb begin
    w_nib[0] = r_w[15:12];
    w_nib[1] = r_w[11:8];
    w_nib[2] = r_w[7:4];
    w_nib[3] = r_w[3:0];
    w_nib[4] = r_h[15:12];
    w_nib[5] = r_h[11:8];
    w_nib[6] = r_h[7:4];
    w_nib[7] = r_h[3:0];
    w_nib[8] = r_i;
  end

  // Plane 0 takes the earliest nibble of the beat; positions past the ninth
  // nibble (only reachable on the last beat) stay zero.
  always_comb begin
    w_body = '0;
    for (int p = 0; p < COLOR_PLANES; p++) begin
      if ((int'(r_beat_cnt) * COLOR_PLANES + p) < 9) begin
        w_body[p*COLOR_BITS +: 4] = w_nib[4'(int'(r_beat_cnt) * COLOR_PLANES + p)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_i        <= '0;
      r_ctrl     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_sof) begin
            r_w    <= im_width;
            r_h    <= im_height;
            r_i    <= im_interlaced;
            r_ctrl <= ctrl_en;
          end
        end
        CTRL_TYPE: begin
          if (dout_ready) r_beat_cnt <= '0;
        end
        CTRL_BODY: begin
          if (dout_ready) r_beat_cnt <= r_beat_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Header beats are built only from state and latched registers so they stay
  // stable under backpressure; DATA is a pure combinational passthrough.
  always_comb begin
    w_next             = r_state;
    dout_data          = '0;
    dout_valid         = 1'b0;
    dout_startofpacket = 1'b0;
    dout_endofpacket   = 1'b0;
    din_ready          = 1'b0;
    case (r_state)
      IDLE: begin
        // Stray non-sop pixels are swallowed; the sop pixel is held off and
        // re-presented once the headers are out.
        din_ready = !w_sof;
        if (w_sof) w_next = ctrl_en ? CTRL_TYPE : DATA_TYPE;
      end
      CTRL_TYPE: begin
        dout_valid         = 1'b1;
        dout_startofpacket = 1'b1;
        dout_data[3:0]     = 4'hF;
        if (dout_ready) w_next = CTRL_BODY;
      end
      CTRL_BODY: begin
        dout_valid       = 1'b1;
        dout_data        = w_body;
        dout_endofpacket = (r_beat_cnt == LAST_BEAT);
        if (dout_ready && (r_beat_cnt == LAST_BEAT)) w_next = DATA_TYPE;
      end
      DATA_TYPE: begin
        dout_valid         = 1'b1;
        dout_startofpacket = 1'b1;
        if (dout_ready) w_next = DATA;
      end
      DATA: begin
        dout_data        = din_data;
        dout_valid       = din_valid;
        dout_endofpacket = din_endofpacket;
        din_ready        = dout_ready;
        if (din_valid && dout_ready && din_endofpacket) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dis_pal_encode.sv
// tb/tb_dis_pal_encode.sv - scoreboard bench for dis_pal_encode
module tb_dis_pal_encode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] din_data = '0;
  logic        din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0, din_ready;
  logic [13:0] dout_data;
  logic        dout_valid, dout_sop, dout_eop;
  logic        dout_ready = 1'b1;
  logic [15:0] im_width = '0, im_height = '0;
  logic [3:0]  im_interlaced = '0;
  logic        ctrl_en = 1'b0;

  logic [7:0]  p2_din_data = '0;
  logic        p2_din_valid = 1'b0, p2_din_sop = 1'b0, p2_din_eop = 1'b0, p2_din_ready;
  logic [7:0]  p2_dout_data;
  logic        p2_dout_valid, p2_dout_sop, p2_dout_eop;
  logic [11:0] p3_din_data = '0;
  logic        p3_din_valid = 1'b0, p3_din_sop = 1'b0, p3_din_eop = 1'b0, p3_din_ready;
  logic [11:0] p3_dout_data;
  logic        p3_dout_valid, p3_dout_sop, p3_dout_eop;
  logic        px_dout_ready = 1'b1;

  always #5 clk = ~clk;

  dis_pal_encode #(.DATA_WIDTH(14), .COLOR_BITS(14), .COLOR_PLANES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .din_data(din_data), .din_valid(din_valid), .din_startofpacket(din_sop),
    .din_endofpacket(din_eop), .din_ready(din_ready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_startofpacket(dout_sop),
    .dout_endofpacket(dout_eop), .dout_ready(dout_ready),
    .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
    .ctrl_en(ctrl_en));

  dis_pal_encode #(.DATA_WIDTH(8), .COLOR_BITS(4), .COLOR_PLANES(2)) u_dut_p2 (
    .clk(clk), .rst_n(rst_n),
    .din_data(p2_din_data), .din_valid(p2_din_valid), .din_startofpacket(p2_din_sop),
    .din_endofpacket(p2_din_eop), .din_ready(p2_din_ready),
    .dout_data(p2_dout_data), .dout_valid(p2_dout_valid), .dout_startofpacket(p2_dout_sop),
    .dout_endofpacket(p2_dout_eop), .dout_ready(px_dout_ready),
    .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
    .ctrl_en(ctrl_en));

  dis_pal_encode #(.DATA_WIDTH(12), .COLOR_BITS(4), .COLOR_PLANES(3)) u_dut_p3 (
    .clk(clk), .rst_n(rst_n),
    .din_data(p3_din_data), .din_valid(p3_din_valid), .din_startofpacket(p3_din_sop),
    .din_endofpacket(p3_din_eop), .din_ready(p3_din_ready),
    .dout_data(p3_dout_data), .dout_valid(p3_dout_valid), .dout_startofpacket(p3_dout_sop),
    .dout_endofpacket(p3_dout_eop), .dout_ready(px_dout_ready),
    .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
    .ctrl_en(ctrl_en));

  typedef struct packed {
    logic        hdr;
    logic        sop;
    logic        eop;
    logic [13:0] data;
  } beat_t;

  beat_t       sb_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  bit          sb_on = 1'b1;
  bit          stall_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [13:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input int k, input logic [15:0] w, input logic [15:0] h,
                                     input logic [3:0] i);
    logic [35:0] v;
    v = {w, h, i};
    if (k > 8) return 4'h0;
    return v[35-4*k -: 4];
  endfunction

  // Header beat for a 4-bit-symbol multi-plane instance; plane 0 in the low bits.
  function automatic logic [11:0] pack_hdr(input int planes, input int beat, input logic [15:0] w,
                                           input logic [15:0] h, input logic [3:0] i);
    logic [11:0] d;
    d = '0;
    for (int p = 0; p < planes; p++) d[4*p +: 4] = nib(beat * planes + p, w, h, i);
    return d;
  endfunction

  initial forever begin
    @(negedge clk);
    dout_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    beat_t e;
    @(negedge clk);
    #3;
    if (sb_on && rst_n) begin
      if (dout_valid) begin
        if (stall_prev) chk("stall_hold", 32'(dout_data), 32'(prev_data));
        if (dout_ready) begin
          chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("beat_data", 32'(dout_data), 32'(e.data));
            chk("beat_sop", 32'(dout_sop), 32'(e.sop));
            chk("beat_eop", 32'(dout_eop), 32'(e.eop));
            if (e.hdr) chk("din_ready_hdr", 32'(din_ready), 32'd0);
          end
        end
      end
      stall_prev = dout_valid && !dout_ready;
      prev_data  = dout_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push(input logic hdr, input logic sop, input logic eop, input logic [13:0] d);
    beat_t b;
    b.hdr = hdr; b.sop = sop; b.eop = eop; b.data = d;
    sb_q.push_back(b);
  endtask

  // Called at a negedge with the beat already on din; returns at a negedge after acceptance.
  task automatic drive_wait(input string tag);
    int  t;
    bit  acc;
    t = 0;
    forever begin
      #3;
      acc = din_valid && din_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
      t++;
      if (t > 300) begin
        chk({tag, "_timeout"}, 32'(t), 32'd0);
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                            input logic ce, input int npix);
    logic [13:0] px;
    im_width = w; im_height = h; im_interlaced = il; ctrl_en = ce;
    if (ce) begin
      push(1'b1, 1'b1, 1'b0, 14'h00F);
      for (int k = 0; k < 9; k++) push(1'b1, 1'b0, k == 8, 14'(nib(k, w, h, il)));
    end
    push(1'b1, 1'b1, 1'b0, 14'h000);
    for (int n = 0; n < npix; n++) begin
      px = 14'($urandom);
      push(1'b0, 1'b0, n == npix - 1, px);
      din_data = px; din_valid = 1'b1; din_sop = (n == 0); din_eop = (n == npix - 1);
      drive_wait("pix");
      // Frame parameters must not leak into an in-flight frame.
      im_width = 16'($urandom); im_height = 16'($urandom); ctrl_en = ~ce;
    end
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    drain("frame_drain");
  endtask

  task automatic run_multiplane();
    logic [13:0] cap2[$], cap3[$];
    logic [13:0] exp2[$], exp3[$];
    int          t;
    im_width = 16'h1234; im_height = 16'h5678; im_interlaced = 4'hA; ctrl_en = 1'b1;
    exp2.push_back({1'b1, 1'b0, 12'h00F});
    for (int b = 0; b < 5; b++) exp2.push_back({1'b0, b == 4, pack_hdr(2, b, 16'h1234, 16'h5678, 4'hA)});
    exp2.push_back({1'b1, 1'b0, 12'h000});
    exp2.push_back({1'b0, 1'b1, 12'h05C});
    exp3.push_back({1'b1, 1'b0, 12'h00F});
    for (int b = 0; b < 3; b++) exp3.push_back({1'b0, b == 2, pack_hdr(3, b, 16'h1234, 16'h5678, 4'hA)});
    exp3.push_back({1'b1, 1'b0, 12'h000});
    exp3.push_back({1'b0, 1'b1, 12'hB3C});
    p2_din_data = 8'h5C; p2_din_valid = 1'b1; p2_din_sop = 1'b1; p2_din_eop = 1'b1;
    p3_din_data = 12'hB3C; p3_din_valid = 1'b1; p3_din_sop = 1'b1; p3_din_eop = 1'b1;
    t = 0;
    while (t < 40) begin
      #3;
      if (p2_dout_valid) cap2.push_back({p2_dout_sop, p2_dout_eop, 4'h0, p2_dout_data});
      if (p3_dout_valid) cap3.push_back({p3_dout_sop, p3_dout_eop, p3_dout_data});
      @(posedge clk);
      if (cap2.size() == exp2.size()) p2_din_valid = 1'b0;
      if (cap3.size() == exp3.size()) p3_din_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    chk("p2_len", 32'(cap2.size()), 32'(exp2.size()));
    chk("p3_len", 32'(cap3.size()), 32'(exp3.size()));
    for (int k = 0; k < exp2.size() && k < cap2.size(); k++) chk("p2_beat", 32'(cap2[k]), 32'(exp2[k]));
    for (int k = 0; k < exp3.size() && k < cap3.size(); k++) chk("p3_beat", 32'(cap3[k]), 32'(exp3[k]));
    p2_din_sop = 1'b0; p2_din_eop = 1'b0; p3_din_sop = 1'b0; p3_din_eop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    @(negedge clk);
    #3;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_sop", 32'(dout_sop), 32'd0);
    chk("rst_eop", 32'(dout_eop), 32'd0);
    chk("rst_data", 32'(dout_data), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(16'h02D0, 16'h0120, 4'h3, 1'b1, 4);
    send_frame(16'h02D0, 16'h0120, 4'h3, 1'b0, 4);

    stall_en = 1'b1;
    for (int f = 0; f < 4; f++)
      send_frame(16'($urandom), 16'($urandom), 4'($urandom), 1'(f % 2 == 0), 3 + f);
    stall_en = 1'b0;
    @(negedge clk);

    // Stray non-sop pixels in IDLE are dropped.
    for (int k = 0; k < 3; k++) begin
      din_data = 14'(k + 5); din_valid = 1'b1; din_sop = 1'b0; din_eop = 1'b0;
      #3;
      chk("stray_ready", 32'(din_ready), 32'd1);
      chk("stray_no_out", 32'(dout_valid), 32'd0);
      @(negedge clk);
    end
    din_valid = 1'b0;
    send_frame(16'h0010, 16'h0008, 4'h1, 1'b1, 1);
    din_data = 14'h1AB; din_valid = 1'b1;
    #3;
    chk("idle_after_single", 32'(dout_valid), 32'd0);
    @(negedge clk);
    din_valid = 1'b0;

    // Reset in the middle of the control body.
    sb_on = 1'b0;
    im_width = 16'h02D7; im_height = 16'h0120; im_interlaced = 4'h3; ctrl_en = 1'b1;
    din_data = 14'h0AA; din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0;
    nb = 0;
    for (int t = 0; t < 30 && nb < 4; t++) begin
      #3;
      if (dout_valid && !dout_sop) nb++;
      if (nb < 4) @(negedge clk);
    end
    chk("body3_data", 32'(dout_data), 32'h7);
    din_valid = 1'b0; din_sop = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    chk("midrst_din_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    sb_on = 1'b1;
    @(negedge clk);
    send_frame(16'h02D0, 16'h0120, 4'h3, 1'b1, 2);

    run_multiplane();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
